// File: rtl/demux_tdm_4.sv
// demux_tdm_4: receive-side 4-slot TDM demultiplexer.
// Takes one ANCHO-bit word per valid beat. i_Sync marks the channel-0 slot.
// Each word is routed to one of four held output registers.
// Also produces per-channel update strobes, a frame-complete pulse, an
// alignment-error pulse and a saturating alignment-error counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// BUSCA    | hunting for the first sync; valid words are discarded
// ALINEADO | locked; slot counter selects the channel for each word
module demux_tdm_4 #(
  parameter int ANCHO = 4,
  parameter int ERR_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [ANCHO-1:0] i_Dato,
  input  logic             i_Valido,
  input  logic             i_Sync,
  output logic [ANCHO-1:0] o_Salida_0,
  output logic [ANCHO-1:0] o_Salida_1,
  output logic [ANCHO-1:0] o_Salida_2,
  output logic [ANCHO-1:0] o_Salida_3,
  output logic [3:0]       o_Nuevo,
  output logic             o_Trama,
  output logic             o_Alineado,
  output logic             o_Error,
  output logic [ERR_W-1:0] o_Errores
);

  typedef enum logic {
    BUSCA    = 1'b0,
    ALINEADO = 1'b1
  } estado_t;

  estado_t          state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [ANCHO-1:0] salida_q [4];
  logic [3:0]       nuevo_q, nuevo_d;
  logic             trama_q, trama_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] errores_q, errores_d;

  // Write enable and target channel for this beat's word.
  logic             wr_en;
  logic [1:0]       wr_ch;

  // Next-state, routing and pulse decode for the current beat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    trama_d   = 1'b0;
    error_d   = 1'b0;
    errores_d = errores_q;
    wr_en     = 1'b0;
    wr_ch     = 2'd0;

    if (i_Valido) begin
      unique case (state_q)
        BUSCA: begin
          if (i_Sync) begin
            wr_en   = 1'b1;
            wr_ch   = 2'd0;
            cnt_d   = 2'd1;
            state_d = ALINEADO;
          end
        end
        ALINEADO: begin
          if (i_Sync) begin
            // A sync always restarts the frame at channel 0. If it
            // arrives mid-frame, the partial frame is dropped and an
            // error is flagged.
            wr_en = 1'b1;
            wr_ch = 2'd0;
            cnt_d = 2'd1;
            if (cnt_q != 2'd0) begin
              error_d = 1'b1;
              if (errores_q != {ERR_W{1'b1}}) begin
                errores_d = errores_q + ERR_W'(1);
              end
            end
          end else begin
            // A missing sync at slot 0 is tolerated: the counter alone
            // keeps the frame in step.
            wr_en = 1'b1;
            wr_ch = cnt_q;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              trama_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = BUSCA;
          cnt_d   = 2'd0;
        end
      endcase
    end

    nuevo_d = wr_en ? (4'b0001 << wr_ch) : 4'b0000;
  end

  // Control state, pulse outputs and error counter.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= BUSCA;
      cnt_q     <= 2'd0;
      nuevo_q   <= 4'b0000;
      trama_q   <= 1'b0;
      error_q   <= 1'b0;
      errores_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nuevo_q   <= nuevo_d;
      trama_q   <= trama_d;
      error_q   <= error_d;
      errores_q <= errores_d;
    end
  end

  // Held per-channel output registers; only the addressed one loads.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int k = 0; k < 4; k++) begin
        salida_q[k] <= '0;
      end
    end else if (wr_en) begin
      salida_q[wr_ch] <= i_Dato;
    end
  end

  assign o_Salida_0 = salida_q[0];
  assign o_Salida_1 = salida_q[1];
  assign o_Salida_2 = salida_q[2];
  assign o_Salida_3 = salida_q[3];
  assign o_Nuevo    = nuevo_q;
  assign o_Trama    = trama_q;
  assign o_Error    = error_q;
  assign o_Errores  = errores_q;
  assign o_Alineado = (state_q == ALINEADO);

endmodule

// File: tb/tb_demux_tdm_4.sv
// Directed bench for demux_tdm_4. A vector table covers per-beat routing.
// Hand sequences cover idle after reset, error-counter saturation and
// mid-frame reset.
// A second instance with ERR_W=2 sees the same stimulus, so that its
// counter saturation can be observed.
module tb_demux_tdm_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dato = 4'h0;
  logic       valido = 1'b0;
  logic       sync = 1'b0;

  logic [3:0] s0, s1, s2, s3, nuevo;
  logic       trama, alineado, err;
  logic [7:0] errs;

  logic [3:0] t0, t1, t2, t3, tnuevo;
  logic       ttrama, talineado, terr;
  logic [1:0] terrs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_tdm_4 #(.ANCHO(4), .ERR_W(8)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Dato(dato), .i_Valido(valido), .i_Sync(sync),
    .o_Salida_0(s0), .o_Salida_1(s1), .o_Salida_2(s2), .o_Salida_3(s3),
    .o_Nuevo(nuevo), .o_Trama(trama), .o_Alineado(alineado),
    .o_Error(err), .o_Errores(errs)
  );

  demux_tdm_4 #(.ANCHO(4), .ERR_W(2)) dut_s (
    .i_Clk(clk), .i_Rst(rst), .i_Dato(dato), .i_Valido(valido), .i_Sync(sync),
    .o_Salida_0(t0), .o_Salida_1(t1), .o_Salida_2(t2), .o_Salida_3(t3),
    .o_Nuevo(tnuevo), .o_Trama(ttrama), .o_Alineado(talineado),
    .o_Error(terr), .o_Errores(terrs)
  );

  typedef struct {
    logic       v;
    logic       s;
    logic [3:0] d;
    logic [3:0] e_nuevo;
    logic       e_trama;
    logic       e_al;
    logic       e_err;
    logic [7:0] e_errs;
    logic [3:0] e_s0, e_s1, e_s2, e_s3;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic v, input logic s, input logic [3:0] d,
                              input logic [3:0] n, input logic t, input logic a,
                              input logic e, input logic [7:0] ec,
                              input logic [3:0] x0, input logic [3:0] x1,
                              input logic [3:0] x2, input logic [3:0] x3);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.e_nuevo = n; r.e_trama = t; r.e_al = a;
    r.e_err = e; r.e_errs = ec; r.e_s0 = x0; r.e_s1 = x1; r.e_s2 = x2; r.e_s3 = x3;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive one beat, wait for the next negedge.
  task automatic beat(input logic v, input logic s, input logic [3:0] d);
    valido = v;
    sync   = s;
    dato   = d;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " salidas"}, {s0, s1, s2, s3}, 32'h0);
    chk({tag, " nuevo"}, nuevo, 32'h0);
    chk({tag, " pulses"}, {trama, err, alineado}, 32'h0);
    chk({tag, " errores"}, errs, 32'h0);
    chk({tag, " errores_sat"}, terrs, 32'h0);
  endtask

  initial begin
    // Pre-sync discard.
    vecs[0]  = mk(1, 0, 4'h9, 4'b0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[1]  = mk(1, 0, 4'h8, 4'b0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Full back-to-back frame.
    vecs[2]  = mk(1, 1, 4'hA, 4'b0001, 0, 1, 0, 0, 4'hA, 4'h0, 4'h0, 4'h0);
    vecs[3]  = mk(1, 0, 4'hB, 4'b0010, 0, 1, 0, 0, 4'hA, 4'hB, 4'h0, 4'h0);
    vecs[4]  = mk(1, 0, 4'hC, 4'b0100, 0, 1, 0, 0, 4'hA, 4'hB, 4'hC, 4'h0);
    vecs[5]  = mk(1, 0, 4'hD, 4'b1000, 1, 1, 0, 0, 4'hA, 4'hB, 4'hC, 4'hD);
    // Gapped frame with sync asserted during gaps.
    vecs[6]  = mk(1, 1, 4'h5, 4'b0001, 0, 1, 0, 0, 4'h5, 4'hB, 4'hC, 4'hD);
    vecs[7]  = mk(0, 1, 4'hF, 4'b0000, 0, 1, 0, 0, 4'h5, 4'hB, 4'hC, 4'hD);
    vecs[8]  = mk(0, 0, 4'h0, 4'b0000, 0, 1, 0, 0, 4'h5, 4'hB, 4'hC, 4'hD);
    vecs[9]  = mk(1, 0, 4'h6, 4'b0010, 0, 1, 0, 0, 4'h5, 4'h6, 4'hC, 4'hD);
    vecs[10] = mk(0, 0, 4'h0, 4'b0000, 0, 1, 0, 0, 4'h5, 4'h6, 4'hC, 4'hD);
    vecs[11] = mk(0, 1, 4'h1, 4'b0000, 0, 1, 0, 0, 4'h5, 4'h6, 4'hC, 4'hD);
    vecs[12] = mk(1, 0, 4'h7, 4'b0100, 0, 1, 0, 0, 4'h5, 4'h6, 4'h7, 4'hD);
    vecs[13] = mk(0, 1, 4'h2, 4'b0000, 0, 1, 0, 0, 4'h5, 4'h6, 4'h7, 4'hD);
    vecs[14] = mk(0, 0, 4'h0, 4'b0000, 0, 1, 0, 0, 4'h5, 4'h6, 4'h7, 4'hD);
    vecs[15] = mk(1, 0, 4'h8, 4'b1000, 1, 1, 0, 0, 4'h5, 4'h6, 4'h7, 4'h8);
    // Misaligned sync at slot 2, then the realigned frame completes.
    vecs[16] = mk(1, 1, 4'h1, 4'b0001, 0, 1, 0, 0, 4'h1, 4'h6, 4'h7, 4'h8);
    vecs[17] = mk(1, 0, 4'h2, 4'b0010, 0, 1, 0, 0, 4'h1, 4'h2, 4'h7, 4'h8);
    vecs[18] = mk(1, 1, 4'h3, 4'b0001, 0, 1, 1, 1, 4'h3, 4'h2, 4'h7, 4'h8);
    vecs[19] = mk(1, 0, 4'h4, 4'b0010, 0, 1, 0, 1, 4'h3, 4'h4, 4'h7, 4'h8);
    vecs[20] = mk(1, 0, 4'h9, 4'b0100, 0, 1, 0, 1, 4'h3, 4'h4, 4'h9, 4'h8);
    vecs[21] = mk(1, 0, 4'hE, 4'b1000, 1, 1, 0, 1, 4'h3, 4'h4, 4'h9, 4'hE);
    // Slot 0 without sync is legal; the next sync at slot 1 is an error.
    vecs[22] = mk(1, 0, 4'hC, 4'b0001, 0, 1, 0, 1, 4'hC, 4'h4, 4'h9, 4'hE);
    vecs[23] = mk(1, 1, 4'h1, 4'b0001, 0, 1, 1, 2, 4'h1, 4'h4, 4'h9, 4'hE);

    // Reset, then idle for 10 cycles.
    repeat (2) @(negedge clk);
    chk_all_zero("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      beat(0, (i % 2) == 1, 4'hF);
      if (i == 9) chk_all_zero("idle");
      else chk({"idle nuevo/al "}, {nuevo, trama, err, alineado}, 32'h0);
    end

    // Table-driven routing.
    for (int i = 0; i < 24; i++) begin
      beat(vecs[i].v, vecs[i].s, vecs[i].d);
      chk($sformatf("v%0d nuevo", i), nuevo, vecs[i].e_nuevo);
      chk($sformatf("v%0d trama", i), trama, vecs[i].e_trama);
      chk($sformatf("v%0d alineado", i), alineado, vecs[i].e_al);
      chk($sformatf("v%0d error", i), err, vecs[i].e_err);
      chk($sformatf("v%0d errores", i), errs, vecs[i].e_errs);
      chk($sformatf("v%0d errores_sat", i), terrs,
          (vecs[i].e_errs > 3) ? 32'd3 : 32'(vecs[i].e_errs));
      chk($sformatf("v%0d salidas", i), {s0, s1, s2, s3},
          {vecs[i].e_s0, vecs[i].e_s1, vecs[i].e_s2, vecs[i].e_s3});
    end

    // Five consecutive syncs, each misaligned (counter is 1 after a sync).
    for (int k = 1; k <= 5; k++) begin
      beat(1, 1, 4'(k));
      chk($sformatf("sat%0d error", k), err, 32'd1);
      chk($sformatf("sat%0d errores", k), errs, 32'(2 + k));
      chk($sformatf("sat%0d errores_sat", k), terrs, (2 + k > 3) ? 32'd3 : 32'(2 + k));
      chk($sformatf("sat%0d salida0", k), s0, 32'(k));
      chk($sformatf("sat%0d nuevo", k), nuevo, 32'b0001);
    end
    beat(0, 0, 4'h0);
    chk("sat_idle error", err, 32'd0);
    chk("sat_hold errores_sat", terrs, 32'd3);

    // Mid-frame reset clears everything immediately.
    beat(1, 1, 4'h6);
    beat(1, 0, 4'h7);
    chk("pre_rst salida1", s1, 32'h7);
    valido = 1'b1; sync = 1'b0; dato = 4'hB;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    chk_all_zero("held_rst");
    rst = 1'b0;
    beat(1, 0, 4'hB);
    chk("post_rst discard", {nuevo, alineado, s2}, 32'h0);
    beat(1, 1, 4'h2);
    chk("post_rst sync", {nuevo, alineado, s0}, {4'b0001, 1'b1, 4'h2});
    beat(1, 0, 4'h3);
    chk("post_rst ch1", {nuevo, s1, trama}, {4'b0010, 4'h3, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
